// File: rtl/aib_io_ctrl_if.sv
// aib_io_ctrl_if
//   Bundles the request side (channel configuration registers) and the
//   pad side (AIB buffer c_* inputs plus datapath status) of aib_io_ctrl.
//
//   Request signals (driven by the configuration registers):
//     i_en                level request, 1 = bring pad up, 0 = bring it down
//     i_cfg_ddr_mode      requested DDR mode
//     i_cfg_async_mode    requested async mode
//     i_cfg_drv_strength  target drive strength, 0..15
//     i_cfg_pull_up       weak pull-up request used while idle
//     i_cfg_pull_down     weak pull-down request used while idle
//   Pad/status signals (driven by the controller):
//     o_io_tx_en, o_io_ddr_mode, o_io_async_mode, o_drv_strength,
//     o_drv_pull_up, o_drv_pull_down  -> buffer configuration
//     o_ready  pad fully active
//     o_busy   sequencing in progress
//
//   modport master: configuration-register side
//   modport slave : controller side
interface aib_io_ctrl_if;
  logic       i_en;
  logic       i_cfg_ddr_mode;
  logic       i_cfg_async_mode;
  logic [3:0] i_cfg_drv_strength;
  logic       i_cfg_pull_up;
  logic       i_cfg_pull_down;

  logic       o_io_tx_en;
  logic       o_io_ddr_mode;
  logic       o_io_async_mode;
  logic [3:0] o_drv_strength;
  logic       o_drv_pull_up;
  logic       o_drv_pull_down;
  logic       o_ready;
  logic       o_busy;

  modport master (
    output i_en, i_cfg_ddr_mode, i_cfg_async_mode, i_cfg_drv_strength,
           i_cfg_pull_up, i_cfg_pull_down,
    input  o_io_tx_en, o_io_ddr_mode, o_io_async_mode, o_drv_strength,
           o_drv_pull_up, o_drv_pull_down, o_ready, o_busy
  );

  modport slave (
    input  i_en, i_cfg_ddr_mode, i_cfg_async_mode, i_cfg_drv_strength,
           i_cfg_pull_up, i_cfg_pull_down,
    output o_io_tx_en, o_io_ddr_mode, o_io_async_mode, o_drv_strength,
           o_drv_pull_up, o_drv_pull_down, o_ready, o_busy
  );
endinterface

// File: rtl/aib_io_ctrl.sv
// aib_io_ctrl
//   Power-up/power-down sequencer for the configuration inputs of an AIB
//   I/O buffer. Latches the requested mode when leaving idle, lets the pad
//   settle with the driver off, then ramps drive strength one step at a
//   time up to the latched target (and back down to zero on release).
//
//   Parameters:
//     SETTLE_CYC  cycles spent in SETUP before the first strength step (>=1)
//     STEP_CYC    cycles each strength value is held during a ramp (>=1)
//   Ports:
//     i_clk    clock, all logic on the rising edge
//     i_rst_n  asynchronous active-low reset
//     bus      aib_io_ctrl_if.slave: request inputs and registered pad outputs
module aib_io_ctrl #(
  parameter int SETTLE_CYC = 16,
  parameter int STEP_CYC   = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  aib_io_ctrl_if.slave  bus
);

  localparam int MAX_CYC = (SETTLE_CYC > STEP_CYC) ? SETTLE_CYC : STEP_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  // The counter is loaded with N-1 and the transition fires on the edge
  // where it reads zero, which gives exactly N cycles in the current phase.
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] STEP_LOAD   = CNT_W'(STEP_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    RAMP_UP,
    ACTIVE,
    RAMP_DN
  } state_t;

  state_t           state;
  logic [3:0]       target;
  logic [CNT_W-1:0] hold_cnt;
  logic             hold_done;

  assign hold_done = (hold_cnt == '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state               <= IDLE;
      target              <= 4'd0;
      hold_cnt            <= '0;
      bus.o_io_tx_en      <= 1'b0;
      bus.o_io_ddr_mode   <= 1'b0;
      bus.o_io_async_mode <= 1'b0;
      bus.o_drv_strength  <= 4'd0;
      bus.o_drv_pull_up   <= 1'b0;
      bus.o_drv_pull_down <= 1'b1;
      bus.o_ready         <= 1'b0;
      bus.o_busy          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.o_io_tx_en     <= 1'b0;
          bus.o_drv_strength <= 4'd0;
          bus.o_ready        <= 1'b0;
          bus.o_busy         <= 1'b0;
          if (bus.i_en) begin
            // Mode is captured here and nowhere else, so it stays stable
            // for the whole time the driver may be on.
            state               <= SETUP;
            target              <= bus.i_cfg_drv_strength;
            bus.o_io_ddr_mode   <= bus.i_cfg_ddr_mode;
            bus.o_io_async_mode <= bus.i_cfg_async_mode;
            bus.o_drv_pull_up   <= 1'b0;
            bus.o_drv_pull_down <= 1'b0;
            bus.o_busy          <= 1'b1;
            hold_cnt            <= SETTLE_LOAD;
          end else begin
            bus.o_drv_pull_up   <= bus.i_cfg_pull_up;
            bus.o_drv_pull_down <= bus.i_cfg_pull_down;
          end
        end

        SETUP: begin
          if (!bus.i_en) begin
            // Abort before the driver was ever enabled.
            state               <= IDLE;
            bus.o_busy          <= 1'b0;
            bus.o_drv_pull_up   <= bus.i_cfg_pull_up;
            bus.o_drv_pull_down <= bus.i_cfg_pull_down;
          end else if (hold_done) begin
            bus.o_io_tx_en <= 1'b1;
            hold_cnt       <= STEP_LOAD;
            if (target == 4'd0) begin
              state              <= ACTIVE;
              bus.o_drv_strength <= 4'd0;
              bus.o_ready        <= 1'b1;
              bus.o_busy         <= 1'b0;
            end else begin
              state              <= RAMP_UP;
              bus.o_drv_strength <= 4'd1;
            end
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end

        RAMP_UP: begin
          if (!bus.i_en) begin
            state    <= RAMP_DN;
            hold_cnt <= STEP_LOAD;
          end else if (hold_done) begin
            hold_cnt <= STEP_LOAD;
            // Compare with >= so a step can never carry strength past target.
            if (bus.o_drv_strength >= target) begin
              state       <= ACTIVE;
              bus.o_ready <= 1'b1;
              bus.o_busy  <= 1'b0;
            end else begin
              bus.o_drv_strength <= bus.o_drv_strength + 4'd1;
            end
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end

        ACTIVE: begin
          if (!bus.i_en) begin
            bus.o_ready <= 1'b0;
            if (bus.o_drv_strength == 4'd0) begin
              state               <= IDLE;
              bus.o_io_tx_en      <= 1'b0;
              bus.o_busy          <= 1'b0;
              bus.o_drv_pull_up   <= bus.i_cfg_pull_up;
              bus.o_drv_pull_down <= bus.i_cfg_pull_down;
            end else begin
              state      <= RAMP_DN;
              bus.o_busy <= 1'b1;
              hold_cnt   <= STEP_LOAD;
            end
          end
        end

        RAMP_DN: begin
          if (bus.i_en) begin
            // Resume toward the target latched at the original bring-up.
            state    <= RAMP_UP;
            hold_cnt <= STEP_LOAD;
          end else if (hold_done) begin
            hold_cnt <= STEP_LOAD;
            // Stepping from 1 (or a stray 0) lands at zero: the driver goes
            // off in the same edge that strength reaches zero.
            if (bus.o_drv_strength <= 4'd1) begin
              state               <= IDLE;
              bus.o_drv_strength  <= 4'd0;
              bus.o_io_tx_en      <= 1'b0;
              bus.o_busy          <= 1'b0;
              bus.o_drv_pull_up   <= bus.i_cfg_pull_up;
              bus.o_drv_pull_down <= bus.i_cfg_pull_down;
            end else begin
              bus.o_drv_strength <= bus.o_drv_strength - 4'd1;
            end
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aib_io_ctrl.sv
// tb_aib_io_ctrl
//   Scoreboard bench for aib_io_ctrl. Each stimulus task works out, from
//   the bring-up/bring-down timing rules, every output change the pad
//   should make and the edge after which it must appear, and queues them.
//   A monitor compares each observed output change against the queue head.
module tb_aib_io_ctrl;

  localparam int SETTLE = 16;
  localparam int STEP   = 8;

  typedef struct {
    int          at_edge;
    logic [10:0] vec;
    string       tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  aib_io_ctrl_if bus ();

  aib_io_ctrl #(
    .SETTLE_CYC (SETTLE),
    .STEP_CYC   (STEP)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int   edge_cnt = 0;
  int   n_tests  = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];

  // Expected pad outputs as of the most recently queued event.
  logic       m_tx, m_ddr, m_async, m_pu, m_pd, m_ready, m_busy;
  logic [3:0] m_str;
  int         m_target;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic logic [10:0] dut_vec();
    return {bus.o_io_tx_en, bus.o_io_ddr_mode, bus.o_io_async_mode,
            bus.o_drv_strength, bus.o_drv_pull_up, bus.o_drv_pull_down,
            bus.o_ready, bus.o_busy};
  endfunction

  function automatic logic [10:0] model_vec();
    return {m_tx, m_ddr, m_async, m_str, m_pu, m_pd, m_ready, m_busy};
  endfunction

  task automatic model_reset();
    m_tx = 0; m_ddr = 0; m_async = 0; m_str = 4'd0;
    m_pu = 0; m_pd = 1; m_ready = 0; m_busy = 0;
  endtask

  task automatic model_go_idle();
    m_tx = 0; m_str = 4'd0; m_ready = 0; m_busy = 0;
    m_pu = bus.i_cfg_pull_up; m_pd = bus.i_cfg_pull_down;
  endtask

  task automatic push_exp(input int at_edge, input string tag);
    exp_t e;
    e.at_edge = at_edge;
    e.vec     = model_vec();
    e.tag     = tag;
    exp_q.push_back(e);
  endtask

  task automatic check_output(input string tag, input logic [10:0] expv);
    n_tests++;
    if (dut_vec() !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got %b expected %b", tag, dut_vec(), expv);
    end
  endtask

  // Monitor: every change of the output vector must match the queue head,
  // both in value and in the edge after which it appeared.
  initial begin
    logic [10:0] prev, cur;
    exp_t        e;
    @(negedge clk);
    prev = dut_vec();
    forever begin
      @(negedge clk);
      cur = dut_vec();
      if (cur !== prev) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("[TB] FAIL unexpected_change: got %b at edge %0d, expected no change from %b",
                   cur, edge_cnt, prev);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e.vec || (e.at_edge >= 0 && e.at_edge != edge_cnt)) begin
            n_fail++;
            $display("[TB] FAIL %s: got %b at edge %0d, expected %b at edge %0d",
                     e.tag, cur, edge_cnt, e.vec, e.at_edge);
          end
        end
      end
      prev = cur;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Wait until the negedge following edge e, optionally scrambling the
  // config inputs that the controller must ignore outside idle.
  task automatic wait_until(input int e, input bit noise_mode, input bit noise_pull);
    while (edge_cnt < e) begin
      @(negedge clk);
      if (noise_mode) begin
        bus.i_cfg_ddr_mode     = 1'($urandom_range(0, 1));
        bus.i_cfg_async_mode   = 1'($urandom_range(0, 1));
        bus.i_cfg_drv_strength = 4'($urandom_range(0, 15));
      end
      if (noise_pull) begin
        bus.i_cfg_pull_up   = 1'($urandom_range(0, 1));
        bus.i_cfg_pull_down = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic idle_set_pulls(input logic pu, input logic pd);
    bus.i_cfg_pull_up   = pu;
    bus.i_cfg_pull_down = pd;
    if (pu != m_pu || pd != m_pd) begin
      m_pu = pu; m_pd = pd;
      push_exp(edge_cnt + 1, "idle_pull_follow");
    end
    @(negedge clk);
  endtask

  task automatic bring_up(input int t, input logic ddr, input logic asy, input bit noise);
    int b;
    bus.i_cfg_drv_strength = 4'(t);
    bus.i_cfg_ddr_mode     = ddr;
    bus.i_cfg_async_mode   = asy;
    bus.i_en               = 1'b1;
    b = edge_cnt + 1;
    m_target = t;
    m_ddr = ddr; m_async = asy; m_pu = 0; m_pd = 0; m_busy = 1;
    push_exp(b, "setup_entry");
    if (t == 0) begin
      m_tx = 1; m_ready = 1; m_busy = 0;
      push_exp(b + SETTLE, "active_target0");
    end else begin
      m_tx = 1;
      for (int k = 1; k <= t; k++) begin
        m_str = 4'(k);
        push_exp(b + SETTLE + (k - 1) * STEP, "ramp_up_step");
      end
      m_ready = 1; m_busy = 0;
      push_exp(b + SETTLE + t * STEP, "ready_rise");
    end
    wait_until(b + SETTLE + t * STEP, noise, noise);
  endtask

  task automatic bring_down(input logic pu, input logic pd);
    int b, s;
    bus.i_cfg_pull_up   = pu;
    bus.i_cfg_pull_down = pd;
    bus.i_en            = 1'b0;
    b = edge_cnt + 1;
    s = int'(m_str);
    m_ready = 0;
    if (s == 0) begin
      model_go_idle();
      push_exp(b, "idle_from_strength0");
    end else begin
      m_busy = 1;
      push_exp(b, "ramp_dn_entry");
      for (int k = s - 1; k >= 1; k--) begin
        m_str = 4'(k);
        push_exp(b + (s - k) * STEP, "ramp_dn_step");
      end
      model_go_idle();
      push_exp(b + s * STEP, "idle_after_ramp_dn");
    end
    wait_until(b + s * STEP, 1'b1, 1'b0);
  endtask

  task automatic abort_setup(input int a);
    int b;
    bus.i_cfg_drv_strength = 4'($urandom_range(0, 15));
    bus.i_cfg_ddr_mode     = 1'($urandom_range(0, 1));
    bus.i_cfg_async_mode   = 1'($urandom_range(0, 1));
    bus.i_en               = 1'b1;
    b = edge_cnt + 1;
    m_ddr = bus.i_cfg_ddr_mode; m_async = bus.i_cfg_async_mode;
    m_pu = 0; m_pd = 0; m_busy = 1;
    push_exp(b, "setup_entry");
    wait_until(b + a - 1, 1'b1, 1'b0);
    bus.i_cfg_pull_up   = 1'($urandom_range(0, 1));
    bus.i_cfg_pull_down = 1'($urandom_range(0, 1));
    bus.i_en            = 1'b0;
    model_go_idle();
    push_exp(b + a, "abort_idle");
    wait_until(b + a, 1'b0, 1'b0);
  endtask

  // From ACTIVE at the target: ramp down to strength d, re-request part way
  // through that hold, and expect a full ramp back up to the old target.
  task automatic apply_stimulus_reversal(input int d);
    int b, s, j, er;
    s = int'(m_str);
    j = int'($urandom_range(1, STEP));
    bus.i_en = 1'b0;
    b = edge_cnt + 1;
    m_ready = 0; m_busy = 1;
    push_exp(b, "ramp_dn_entry");
    for (int k = s - 1; k >= d; k--) begin
      m_str = 4'(k);
      push_exp(b + (s - k) * STEP, "ramp_dn_step");
    end
    er = b + (s - d) * STEP + j;
    wait_until(er - 1, 1'b1, 1'b1);
    bus.i_en = 1'b1;
    for (int k = d + 1; k <= m_target; k++) begin
      m_str = 4'(k);
      push_exp(er + (k - d) * STEP, "ramp_up_again");
    end
    m_ready = 1; m_busy = 0;
    push_exp(er + (m_target - d + 1) * STEP, "ready_again");
    wait_until(er + (m_target - d + 1) * STEP, 1'b1, 1'b1);
  endtask

  task automatic apply_stimulus_reset_mid_ramp();
    int b;
    bus.i_cfg_drv_strength = 4'($urandom_range(3, 15));
    bus.i_cfg_ddr_mode     = 1'b1;
    bus.i_cfg_async_mode   = 1'b1;
    bus.i_en               = 1'b1;
    b = edge_cnt + 1;
    m_ddr = 1; m_async = 1; m_pu = 0; m_pd = 0; m_busy = 1;
    push_exp(b, "setup_entry");
    m_tx = 1; m_str = 4'd1;
    push_exp(b + SETTLE, "ramp_up_step");
    m_str = 4'd2;
    push_exp(b + SETTLE + STEP, "ramp_up_step");
    wait_until(b + SETTLE + STEP + 2, 1'b1, 1'b1);
    model_reset();
    push_exp(-1, "reset_seen_by_monitor");
    #2 rst_n = 1'b0;
    #1 check_output("async_reset_immediate", model_vec());
    bus.i_en            = 1'b0;
    bus.i_cfg_pull_up   = 1'b0;
    bus.i_cfg_pull_down = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int t;
    rst_n                  = 1'b0;
    bus.i_en               = 1'b0;
    bus.i_cfg_ddr_mode     = 1'b0;
    bus.i_cfg_async_mode   = 1'b0;
    bus.i_cfg_drv_strength = 4'd0;
    bus.i_cfg_pull_up      = 1'b0;
    bus.i_cfg_pull_down    = 1'b1;
    model_reset();
    m_target = 0;
    repeat (2) @(negedge clk);
    check_output("reset_state", model_vec());
    rst_n = 1'b1;
    @(negedge clk);

    idle_set_pulls(1'b1, 1'b0);
    idle_set_pulls(1'b0, 1'b0);
    idle_set_pulls(1'b0, 1'b1);

    bring_up(4, 1'b1, 1'b0, 1'b0);
    bring_down(1'b0, 1'b1);

    bring_up(0, 1'b0, 1'b1, 1'b1);
    bring_down(1'b1, 1'b0);

    abort_setup(5);
    abort_setup(int'($urandom_range(1, SETTLE)));

    bring_up(4, 1'b1, 1'b1, 1'b0);
    apply_stimulus_reversal(2);
    bring_down(1'b0, 1'b1);

    for (int it = 0; it < 4; it++) begin
      t = int'($urandom_range(0, 15));
      bring_up(t, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
      if (t >= 2) apply_stimulus_reversal(int'($urandom_range(1, t - 1)));
      bring_down(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      idle_set_pulls(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    apply_stimulus_reset_mid_ramp();

    repeat (5) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL scoreboard_drain: %0d events still pending, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aib_io_ctrl.md
# aib_io_ctrl

Power-up/power-down sequencer for the configuration inputs of an AIB I/O buffer (one pad or a bundle sharing one configuration).
- Latches the requested mode (DDR/SDR, async, target drive strength, idle pulls) and holds it stable while the driver is active.
- Gives the pad a settle period before the driver is enabled, then ramps drive strength one step at a time in both directions.
- Tells the datapath when the pad is fully active.
- Sits between the channel configuration registers and the buffer's `c_*` inputs.

## Interface

Parameters:
- `SETTLE_CYC`, default 16: cycles in SETUP (mode applied, driver off) before the first strength step; must be ≥1.
- `STEP_CYC`, default 8: cycles each drive-strength value is held during a ramp; must be ≥1.

Ports:
- `i_clk` input 1: the single clock. All logic is on its rising edge.
- `i_rst_n` input 1: reset, asynchronous and active-low.
- `i_en` input 1: level request. 1 = bring the pad up; 0 = bring it down.
- `i_cfg_ddr_mode` input 1: requested DDR mode. Sampled only on leaving IDLE.
- `i_cfg_async_mode` input 1: requested async mode. Sampled only on leaving IDLE.
- `i_cfg_drv_strength` input 4: target drive strength (0–15). Sampled only on leaving IDLE.
- `i_cfg_pull_up` input 1: weak pull-up request, applied in IDLE.
- `i_cfg_pull_down` input 1: weak pull-down request, applied in IDLE.
- `o_io_tx_en` output 1: drives the buffer's `c_io_tx_en`.
- `o_io_ddr_mode` output 1: drives `c_io_ddr_mode`.
- `o_io_async_mode` output 1: drives `c_io_async_mode`.
- `o_drv_strength` output 4: drives `c_drv_strength`.
- `o_drv_pull_up` output 1: drives `c_drv_pull_up`.
- `o_drv_pull_down` output 1: drives `c_drv_pull_down`.
- `o_ready` output 1: high only in ACTIVE; the datapath may send and receive.
- `o_busy` output 1: high in SETUP, RAMP_UP and RAMP_DN.

## Operation

- **Registered outputs:** every output is a flop. Reset values:
  - `o_io_tx_en` = 0, `o_io_ddr_mode` = 0, `o_io_async_mode` = 0
  - `o_drv_strength` = 0, `o_drv_pull_up` = 0, `o_drv_pull_down` = 1
  - `o_ready` = 0, `o_busy` = 0
  - state = IDLE
- **Shadow register:** holds the target strength. Reset value 0. Loaded only on the IDLE→SETUP transition.
- **Hold counter:** sized for max(SETTLE_CYC, STEP_CYC). Reloaded on every state entry and on every strength step.
- **IDLE:**
  - `o_io_tx_en` = 0, strength = 0.
  - Pull outputs follow `i_cfg_pull_*` with one cycle of delay.
  - DDR/async outputs keep their last values.
  - `i_en` = 1 → SETUP: latch all `i_cfg_*` mode bits into the shadow and drive DDR/async from them; force both pulls to 0.
- **SETUP:**
  - Lasts SETTLE_CYC cycles.
  - At the end, if target = 0 → ACTIVE with `o_io_tx_en` = 1, strength = 0.
  - Otherwise → RAMP_UP with `o_io_tx_en` = 1, strength = 1.
  - `i_en` = 0 at any point → IDLE next cycle. The driver is never enabled and the pulls are restored.
- **RAMP_UP:**
  - Each strength value is held STEP_CYC cycles.
  - At the end of a hold: if strength == target → ACTIVE; else strength +1.
  - `i_en` = 0 → RAMP_DN next cycle, starting from the current strength.
- **ACTIVE:**
  - `o_ready` = 1, all outputs static.
  - `i_en` = 0 → RAMP_DN, or → IDLE if strength = 0.
- **RAMP_DN:**
  - Each value is held STEP_CYC cycles, then decremented.
  - When a decrement would reach 0: → IDLE with strength = 0 and `o_io_tx_en` = 0 in the same cycle.
  - `i_en` = 1 → RAMP_UP from the current strength toward the latched target; the shadow is not reloaded and the counter restarts.
- **Config inputs:** changes to `i_cfg_ddr_mode`, `i_cfg_async_mode` or `i_cfg_drv_strength` outside IDLE are ignored. Changes to `i_cfg_pull_*` are ignored until the next IDLE.
- **Strength arithmetic:** 4-bit, saturating. It never exceeds the target and never goes below 0; no wrap-around.

## Timing

Cycle 0 is the edge at which `i_en` is sampled.

- **Bring-up:**
  - Cycle 1: SETUP, `o_busy` = 1, DDR/async updated, pulls = 0.
  - Strength k (k ≥ 1) appears at cycle SETTLE_CYC + 1 + (k−1)·STEP_CYC.
  - `o_ready` rises at cycle SETTLE_CYC + 1 + T·STEP_CYC, where T is the target; `o_busy` falls in the same cycle.
- **Bring-down from ACTIVE at strength S:**
  - Cycle 1: `o_ready` = 0, `o_busy` = 1.
  - Strength k appears at cycle 1 + (S−k)·STEP_CYC.
  - IDLE (tx_en = 0, pulls restored, `o_busy` = 0) at cycle 1 + S·STEP_CYC.
- **Reset mid-operation:** all outputs return to their reset values asynchronously. Deassertion is synchronized externally.

## Test plan

- **Bring-up:** reset, then `i_en` = 1 with target 4, DDR = 1, pull_down = 1 (SETTLE 16, STEP 8) → strength 1/2/3/4 at cycles 17/25/33/41; `o_ready` at 49; pull_down drops at cycle 1.
- **Bring-down:** from ACTIVE at strength 4, `i_en` = 0 → strength 3/2/1 at cycles 9/17/25; IDLE at 33 with tx_en = 0 and pull_down = 1.
- **Target 0:** target 0 → ACTIVE at cycle 17 with tx_en = 1, strength 0; `i_en` = 0 → IDLE at cycle 1.
- **Abort in SETUP:** `i_en` drops at cycle 5 → IDLE at 6; tx_en never rises.
- **Reversal:** `i_en` = 0 in RAMP_DN at strength 2, then 1 during the hold → ramps back up to target 4; config changes made meanwhile are ignored.
- **Async reset:** assert `i_rst_n` = 0 mid-RAMP_UP → all outputs at reset values immediately, without waiting for a clock edge.
